// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around mem_port_arbiter.
// The arbiter takes the slave view; the core and the memory model take the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_enable;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_enable;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  logic              protocol_err;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output protocol_err
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_address, d_wdata, d_byte_enable,
    output mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  protocol_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one hold-until-resp memory port between a fetch
// requester and a data requester; a grant stays locked until the memory responds.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] { S_IDLE, S_BUSY, S_DONE } state_t;
  typedef enum logic       { P_I, P_D } port_t;

  state_t            r_state;
  port_t             r_owner;
  port_t             r_last;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_address;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_byte_enable;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;
  logic              r_protocol_err;

  logic w_i_pend;
  logic w_d_pend;
  logic w_d_illegal;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_pend    = bus.i_read;
  assign w_d_pend    = bus.d_read ^ bus.d_write;
  assign w_d_illegal = bus.d_read & bus.d_write;

  // On a tie the port that was not served last wins.
  assign w_grant_i = w_i_pend & (~w_d_pend | (r_last == P_D));
  assign w_grant_d = w_d_pend & (~w_i_pend | (r_last == P_I));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_owner           <= P_I;
      r_last            <= P_D;
      r_mem_read        <= 1'b0;
      r_mem_write       <= 1'b0;
      r_mem_address     <= '0;
      r_mem_wdata       <= '0;
      r_mem_byte_enable <= '0;
      r_i_rdata         <= '0;
      r_d_rdata         <= '0;
      r_i_resp          <= 1'b0;
      r_d_resp          <= 1'b0;
      r_protocol_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // pre-edge values; the strobes below default low and are overridden later.
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
      r_protocol_err <= ((r_state == S_IDLE) && w_d_illegal) ||
                        ((r_state != S_BUSY) && bus.mem_resp);

      case (r_state)
        S_IDLE: begin
          if (w_grant_i) begin
            r_mem_read        <= 1'b1;
            r_mem_write       <= 1'b0;
            r_mem_address     <= bus.i_address;
            r_mem_wdata       <= '0;
            r_mem_byte_enable <= '1;
            r_owner           <= P_I;
            r_state           <= S_BUSY;
          end else if (w_grant_d) begin
            r_mem_read        <= bus.d_read;
            r_mem_write       <= bus.d_write;
            r_mem_address     <= bus.d_address;
            r_mem_wdata       <= bus.d_wdata;
            r_mem_byte_enable <= bus.d_byte_enable;
            r_owner           <= P_D;
            r_state           <= S_BUSY;
          end
        end

        S_BUSY: begin
          if (bus.mem_resp) begin
            if (r_owner == P_I) begin
              r_i_rdata <= bus.mem_rdata;
              r_i_resp  <= 1'b1;
            end else begin
              r_d_rdata <= bus.mem_rdata;
              r_d_resp  <= 1'b1;
            end
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_last      <= r_owner;
            r_state     <= S_DONE;
          end
        end

        // One settle cycle so the requester can drop its request before resampling.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_read        = r_mem_read;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_address     = r_mem_address;
  assign bus.mem_wdata       = r_mem_wdata;
  assign bus.mem_byte_enable = r_mem_byte_enable;
  assign bus.i_rdata         = r_i_rdata;
  assign bus.i_resp          = r_i_resp;
  assign bus.d_rdata         = r_d_rdata;
  assign bus.d_resp          = r_d_resp;
  assign bus.protocol_err    = r_protocol_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level
// reference: expected data comes from a golden word store updated in completion order.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp      = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int rw_overlap = 0;

  // Memory responder state: mem_wait wait states before each mem_resp.
  bit mem_auto     = 1'b1;
  bit mem_rand     = 1'b0;
  bit mem_done     = 1'b0;
  int mem_wait_fix = 2;
  int mem_wait     = 2;
  int mem_cnt      = 0;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] gold      [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_store.exists(a) ? mem_store[a] : init_word(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_word(a);
  endfunction

  task automatic gold_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    gold[a] = merge(gold_rd(a), d, be);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_step();
    if (!mem_auto) return;
    if (bus.mem_read || bus.mem_write) begin
      if (!mem_done && mem_cnt >= mem_wait) begin
        bus.mem_resp = 1'b1;
        mem_done     = 1'b1;
        if (bus.mem_read) bus.mem_rdata = mem_rd(bus.mem_address);
        else mem_store[bus.mem_address] = merge(mem_rd(bus.mem_address), bus.mem_wdata,
                                                bus.mem_byte_enable);
      end else begin
        if (!mem_done) mem_cnt++;
        bus.mem_resp = 1'b0;
      end
    end else begin
      bus.mem_resp = 1'b0;
      mem_done     = 1'b0;
      mem_cnt      = 0;
      mem_wait     = mem_rand ? int'($urandom_range(0, 5)) : mem_wait_fix;
    end
  endtask

  // Advance to the next falling edge, observe, then let the memory react.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (bus.mem_read && bus.mem_write) rw_overlap++;
    mem_step();
  endtask

  task automatic wait_grant(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle();
      if (bus.mem_read || bus.mem_write) got = 1'b1;
    end
    check({tag, "_granted"}, got, 1);
  endtask

  task automatic wait_resp(input bit port_d, input string tag, output logic [31:0] rdata);
    bit got;
    got   = 1'b0;
    rdata = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle();
      if (port_d ? bus.d_resp : bus.i_resp) begin
        got   = 1'b1;
        rdata = port_d ? bus.d_rdata : bus.i_rdata;
      end
    end
    check(tag, got, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_read"},  bus.mem_read, 0);
    check({tag, "_mem_write"}, bus.mem_write, 0);
    check({tag, "_mem_addr"},  bus.mem_address, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    check({tag, "_mem_be"},    bus.mem_byte_enable, 0);
    check({tag, "_i_rdata"},   bus.i_rdata, 0);
    check({tag, "_d_rdata"},   bus.d_rdata, 0);
    check({tag, "_i_resp"},    bus.i_resp, 0);
    check({tag, "_d_resp"},    bus.d_resp, 0);
    check({tag, "_perr"},      bus.protocol_err, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int n_i, n_d, n_bus, n_err, resp_lat, t0;
    bit got;
    int issued, done_cnt, max_age, i_age, d_age, i_idle, d_idle;
    bit i_act, d_act, d_wr;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_be;

    rst                = 1'b0;
    bus.i_read         = 1'b0;
    bus.i_address      = '0;
    bus.d_read         = 1'b0;
    bus.d_write        = 1'b0;
    bus.d_address      = '0;
    bus.d_wdata        = '0;
    bus.d_byte_enable  = '0;
    bus.mem_rdata      = '0;
    bus.mem_resp       = 1'b0;

    // Reset state, then a single fetch with two wait states.
    repeat (3) cycle();
    check_all_zero("reset");
    mem_store[32'h60] = 32'h0000_0013;
    gold[32'h60]      = 32'h0000_0013;
    rst           = 1'b1;
    bus.i_read    = 1'b1;
    bus.i_address = 32'h60;
    t0 = cyc;
    cycle();
    check("fetch_mem_read_rise", bus.mem_read, 1);
    check("fetch_mem_write", bus.mem_write, 0);
    check("fetch_addr", bus.mem_address, 32'h60);
    check("fetch_be", bus.mem_byte_enable, 4'hF);
    n_i = 0; n_d = 0; resp_lat = 0; rd = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (bus.i_resp) begin
        n_i++;
        resp_lat   = cyc - t0;
        rd         = bus.i_rdata;
        bus.i_read = 1'b0;
      end
      if (bus.d_resp) n_d++;
    end
    check("fetch_resp_count", n_i, 1);
    check("fetch_resp_latency", resp_lat, 4);
    check("fetch_rdata", rd, 32'h13);
    check("fetch_no_d_resp", n_d, 0);

    // Tie after reset: fetch first, then the held write, then fetch again.
    rst = 1'b0; cycle(); cycle(); rst = 1'b1; cycle();
    bus.i_read        = 1'b1;
    bus.i_address     = 32'h40;
    bus.d_write       = 1'b1;
    bus.d_address     = 32'h100;
    bus.d_wdata       = 32'hDEAD_BEEF;
    bus.d_byte_enable = 4'h3;
    wait_grant("tie1");
    check("tie1_is_fetch_rd", bus.mem_read, 1);
    check("tie1_is_fetch_wr", bus.mem_write, 0);
    check("tie1_addr", bus.mem_address, 32'h40);
    wait_resp(1'b0, "tie1_i_resp", rd);
    check("tie1_i_rdata", rd, gold_rd(32'h40));
    bus.i_read = 1'b0;
    cycle();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h44;
    wait_grant("tie2");
    check("tie2_is_write", bus.mem_write, 1);
    check("tie2_not_read", bus.mem_read, 0);
    check("tie2_addr", bus.mem_address, 32'h100);
    check("tie2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("tie2_be", bus.mem_byte_enable, 4'h3);
    bus.d_address     = 32'h200;
    bus.d_wdata       = 32'h0;
    bus.d_byte_enable = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle();
      if (bus.mem_write) begin
        check("busy_addr_hold", bus.mem_address, 32'h100);
        check("busy_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
      end
      if (bus.d_resp) got = 1'b1;
    end
    check("tie2_d_resp", got, 1);
    gold_wr(32'h100, 32'hDEAD_BEEF, 4'h3);
    bus.d_write   = 1'b0;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h100;
    wait_grant("tie3");
    check("tie3_is_fetch", bus.mem_read, 1);
    check("tie3_addr", bus.mem_address, 32'h44);
    wait_resp(1'b0, "tie3_i_resp", rd);
    check("tie3_i_rdata", rd, gold_rd(32'h44));
    bus.i_read = 1'b0;
    wait_grant("tie3_load");
    check("tie3_load_addr", bus.mem_address, 32'h100);
    wait_resp(1'b1, "tie3_d_resp", rd);
    check("tie3_load_rdata", rd, gold_rd(32'h100));
    bus.d_read = 1'b0;

    // Illegal data request alone: error pulse, no grant, no resp.
    repeat (3) cycle();
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    bus.d_address = 32'h300;
    cycle();
    check("illegal_perr", bus.protocol_err, 1);
    check("illegal_no_rd", bus.mem_read, 0);
    check("illegal_no_wr", bus.mem_write, 0);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    n_d = 0; n_bus = 0; n_err = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (bus.d_resp) n_d++;
      if (bus.mem_read || bus.mem_write) n_bus++;
      if (bus.protocol_err) n_err++;
    end
    check("illegal_perr_one_cycle", n_err, 0);
    check("illegal_no_d_resp", n_d, 0);
    check("illegal_no_mem_req", n_bus, 0);

    // Illegal data request alongside a fetch: fetch still granted.
    bus.i_read    = 1'b1;
    bus.i_address = 32'h48;
    bus.d_read    = 1'b1;
    bus.d_write   = 1'b1;
    cycle();
    check("illegal_fetch_perr", bus.protocol_err, 1);
    check("illegal_fetch_grant", bus.mem_read, 1);
    check("illegal_fetch_addr", bus.mem_address, 32'h48);
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    wait_resp(1'b0, "illegal_fetch_resp", rd);
    check("illegal_fetch_rdata", rd, gold_rd(32'h48));
    bus.i_read = 1'b0;

    // Stray mem_resp in IDLE.
    repeat (3) cycle();
    mem_auto     = 1'b0;
    bus.mem_resp = 1'b1;
    cycle();
    check("stray_perr", bus.protocol_err, 1);
    check("stray_no_rd", bus.mem_read, 0);
    check("stray_no_i_resp", bus.i_resp, 0);
    check("stray_no_d_resp", bus.d_resp, 0);
    bus.mem_resp = 1'b0;
    cycle();
    check("stray_perr_clear", bus.protocol_err, 0);
    mem_auto      = 1'b1;
    bus.i_read    = 1'b1;
    bus.i_address = 32'h4C;
    cycle();
    check("stray_then_grant", bus.mem_read, 1);
    wait_resp(1'b0, "stray_then_resp", rd);
    check("stray_then_rdata", rd, gold_rd(32'h4C));
    bus.i_read = 1'b0;

    // Reset while BUSY: everything clears, held request is re-granted.
    mem_wait_fix = 4;
    repeat (3) cycle();
    bus.i_read    = 1'b1;
    bus.i_address = 32'h80;
    cycle();
    check("rstmid_busy", bus.mem_read, 1);
    rst = 1'b0;
    cycle();
    check_all_zero("rstmid");
    rst = 1'b1;
    cycle();
    check("rstmid_regrant", bus.mem_read, 1);
    check("rstmid_regrant_addr", bus.mem_address, 32'h80);
    wait_resp(1'b0, "rstmid_i_resp", rd);
    check("rstmid_i_rdata", rd, gold_rd(32'h80));
    bus.i_read = 1'b0;

    // Randomized back-to-back traffic, 0-5 wait states.
    mem_rand = 1'b1;
    repeat (3) cycle();
    issued = 0; done_cnt = 0; max_age = 0; i_age = 0; d_age = 0; i_idle = 0; d_idle = 0;
    i_act = 1'b0; d_act = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    for (int c = 0; c < 40000 && (issued < 1000 || i_act || d_act); c++) begin
      cycle();
      if (bus.i_resp) begin
        check("stress_i_resp_expected", i_act, 1);
        if (i_act) begin
          check("stress_i_rdata", bus.i_rdata, gold_rd(i_addr));
          i_act      = 1'b0;
          bus.i_read = 1'b0;
          i_idle     = int'($urandom_range(0, 2));
          done_cnt++;
        end
      end
      if (bus.d_resp) begin
        check("stress_d_resp_expected", d_act, 1);
        if (d_act) begin
          if (d_wr) gold_wr(d_addr, d_wdata, d_be);
          else check("stress_d_rdata", bus.d_rdata, gold_rd(d_addr));
          d_act       = 1'b0;
          bus.d_read  = 1'b0;
          bus.d_write = 1'b0;
          d_idle      = int'($urandom_range(0, 2));
          done_cnt++;
        end
      end
      if (i_act) begin i_age++; if (i_age > max_age) max_age = i_age; end
      if (d_act) begin d_age++; if (d_age > max_age) max_age = d_age; end
      if (!i_act) begin
        if (i_idle > 0) i_idle--;
        else if (issued < 1000) begin
          i_act         = 1'b1;
          i_age         = 0;
          issued++;
          i_addr        = 32'($urandom_range(0, 15)) << 2;
          bus.i_read    = 1'b1;
          bus.i_address = i_addr;
        end
      end
      if (!d_act) begin
        if (d_idle > 0) d_idle--;
        else if (issued < 1000) begin
          d_act             = 1'b1;
          d_age             = 0;
          issued++;
          d_wr              = 1'($urandom_range(0, 1));
          d_addr            = 32'($urandom_range(0, 15)) << 2;
          d_wdata           = $urandom;
          d_be              = 4'($urandom_range(0, 15));
          bus.d_read        = ~d_wr;
          bus.d_write       = d_wr;
          bus.d_address     = d_addr;
          bus.d_wdata       = d_wdata;
          bus.d_byte_enable = d_be;
        end
      end
    end
    check("stress_all_done", done_cnt, 1000);
    check("stress_bounded_wait", max_age <= 60, 1);
    check("mem_rw_never_both", rw_overlap, 0);
    for (int a = 0; a < 16; a++)
      check("stress_final_mem", mem_rd(32'(a) << 2), gold_rd(32'(a) << 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port of the mp2 core (`mem_read`/`mem_write`/`mem_resp` handshake) between an instruction-fetch requester and a data-access requester. It sits between the core's split fetch/data interfaces and the memory model or cache. Each requester and the memory side see the same hold-until-resp protocol the core already uses. Arbitration is round-robin, and a granted transaction is locked until the memory responds.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `i_read`  in  1  fetch read request, held until `i_resp`
- `i_address`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetch read data, valid with `i_resp`
- `i_resp`  out  1  one-cycle fetch completion pulse
- `d_read`, `d_write`  in  1  data read/write request, held until `d_resp`
- `d_address`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_byte_enable`  in  DATA_W/8  store byte mask
- `d_rdata`  out  DATA_W  load data, valid with `d_resp`
- `d_resp`  out  1  one-cycle data completion pulse
- `mem_read`, `mem_write`  out  1  downstream request, held until `mem_resp`
- `mem_address`  out  ADDR_W  downstream address
- `mem_wdata`  out  DATA_W  downstream store data
- `mem_byte_enable`  out  DATA_W/8  downstream byte mask
- `mem_rdata`  in  DATA_W  downstream read data
- `mem_resp`  in  1  downstream completion
- `protocol_err`  out  1  one-cycle pulse on illegal requester or memory behaviour

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Internal register `owner` is I or D. Register `last` records the last-served port.
- **IDLE**
  - Requesters are sampled. `i_pend = i_read`. `d_pend = d_read ^ d_write`.
  - Only one pending: grant it.
  - Both pending: grant the port opposite to `last`.
  - On grant, register address, wdata, byte enable and direction into the `mem_*` outputs, set `owner`, and go to BUSY.
  - Fetch grants always drive `mem_read=1`, `mem_write=0` and `mem_byte_enable` all ones.
- **BUSY**
  - `mem_*` outputs are held constant.
  - Requester inputs are ignored; changes mid-transaction have no effect.
  - On `mem_resp=1`: capture `mem_rdata` into the owner's rdata register, deassert `mem_read`/`mem_write`, update `last=owner`, and go to DONE.
- **DONE**
  - The owner's `*_resp` is 1 for exactly this cycle, with `*_rdata` valid. Writes also pulse resp; rdata is don't-care for writes.
  - Always returns to IDLE next cycle.
  - This cycle lets the requester drop its request before IDLE resamples, so it cannot be double-granted.
- **Errors**
  - `d_read & d_write` in IDLE: the data request is not granted, `protocol_err` pulses, and a fetch may still be granted.
  - `mem_resp=1` outside BUSY: ignored, `protocol_err` pulses.
- `mem_read` and `mem_write` are never both 1.
- `*_rdata` holds its last captured value until the next capture for that port.

## Timing
- **Reset values** (applied when `rst=0` at a clock edge, in any state, including mid-transaction):
  - State IDLE, `last=D`, so fetch wins the first tie.
  - All of `mem_read`, `mem_write`, `mem_address`, `mem_wdata`, `mem_byte_enable`, `i_rdata`, `d_rdata`, `i_resp`, `d_resp` and `protocol_err` are 0.
  - An in-flight transaction is dropped with no resp.
- **Latency**, with request first seen in IDLE in cycle N:
  - `mem_read`/`mem_write` rise in cycle N+1.
  - If `mem_resp` is seen in cycle M (M ≥ N+1), `*_resp` is high in cycle M+1 and IDLE is reached in cycle M+2.
  - Minimum turnaround with zero-wait memory (`mem_resp` in N+1) is 3 cycles per transaction.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Requester obligation:** deassert the request in the cycle after `*_resp`. A request still high in IDLE is treated as a new request.

## Test plan
- **Reset, then single fetch.** Drive `i_read=1`, `i_address=0x60`; memory responds 2 cycles later with `0x00000013`. Required: `mem_read` rises the cycle after the request, `mem_byte_enable=4'hF`, `i_resp` pulses once with `i_rdata=0x13`, and `d_resp` stays 0.
- **Tie, round-robin.** Assert `i_read` and `d_write` together, with `d_address=0x100`, `d_wdata=0xDEADBEEF`, `d_byte_enable=4'h3`, and hold both. Required: fetch is served first; the second transaction is the write with exactly those values on `mem_*`; a third tie is served fetch-first again.
- **Mid-transaction change.** After the grant, change `d_address` to `0x200` while in BUSY. Required: `mem_address` stays `0x100` until `mem_resp`.
- **Illegal data request.** Drive `d_read=d_write=1` in IDLE with `i_read=0`. Required: `protocol_err` pulses for one cycle, `mem_read`/`mem_write` stay 0, and there is no `d_resp`. Separately, a stray `mem_resp` in IDLE gives a `protocol_err` pulse and no state change.
- **Reset mid-op.** Pull `rst=0` while in BUSY. Required: the next cycle has all outputs 0 and state IDLE, and the held request is re-granted after `rst=1`.
- **Back-to-back stress.** Drive 1000 random fetch and load/store requests against a memory with 0–5 wait states. Required: every request gets exactly one resp, data matches the reference memory, and `mem_read & mem_write` is never 1.
